muldiv_sequencer: RTL and testbench

//  Multi-cycle controller and datapath for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/muldiv_iter_core.sv | 60 ++++++
 rtl/muldiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/M-extension definitions: M-group alu_control codes and the
// multiply/divide sequencer state encoding. XLEN-independent.
package alu_pkg;

    localparam logic [4:0] ALU_MULHU  = 5'b01000;
    localparam logic [4:0] ALU_MUL    = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULH   = 5'b01011;
    localparam logic [4:0] ALU_DIVU   = 5'b01100;
    localparam logic [4:0] ALU_DIV    = 5'b01101;
    localparam logic [4:0] ALU_REMU   = 5'b01110;
    localparam logic [4:0] ALU_REM    = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply or restoring divide.
// After XLEN steps {hi,lo} holds the product, or hi=remainder and lo=quotient.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] init_a,
    input  logic [XLEN-1:0] init_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] m;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, m};
        hi_next   = hi;
        lo_next   = lo;
        if (is_div) begin
            // remainder stays below m, so a clear sign bit means the trial subtract fits
            if (!div_diff[XLEN]) begin
                hi_next = div_diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = div_shift[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
            m  <= '0;
        end else if (init) begin
            hi <= '0;
            lo <= init_a;
            m  <= init_b;
        end else if (step) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, sign handling, special cases, handshakes.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_rd,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_rd,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t state, state_next;
    logic [CNT_W-1:0] counter;

    logic            op_div, a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            illegal, div_zero, div_ovf, fast_mul, spec_hit;
    logic [XLEN-1:0] spec_val;

    logic            is_div_q, sel_hi_q, neg_q;
    logic            core_init, core_step, load_special, load_fix;
    logic [XLEN-1:0] core_hi, core_lo;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_res, div_fix, fix_res;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_full;
`endif

    // Request decode: bit 2 splits mul/div, low bits pick signedness and result half.
    always_comb begin
        op_div   = req_op[2];
        a_sgn    = op_div ? req_op[0] : req_op[1];
        b_sgn    = op_div ? req_op[0] : (req_op[1] & req_op[0]);
        sa       = a_sgn & req_a[XLEN-1];
        sb       = b_sgn & req_b[XLEN-1];
        abs_a    = sa ? (~req_a + 1'b1) : req_a;
        abs_b    = sb ? (~req_b + 1'b1) : req_b;
        illegal  = (req_op[4:3] != 2'b01);
        div_zero = op_div & (req_b == '0);
        div_ovf  = op_div & req_op[0] & (req_a == INT_MIN) & (req_b == '1);
`ifdef MULDIV_FAST_MUL_EN
        fast_mul = ~op_div;
`else
        fast_mul = 1'b0;
`endif
        spec_hit = illegal | div_zero | div_ovf | fast_mul;
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_a    = {a_sgn & req_a[XLEN-1], req_a};
        fast_b    = {b_sgn & req_b[XLEN-1], req_b};
        fast_full = fast_a * fast_b;
    end
`endif

    always_comb begin
        spec_val = '0;
        if (illegal) begin
            spec_val = '0;
        end else if (div_zero) begin
            spec_val = req_op[1] ? req_a : '1;
        end else if (div_ovf) begin
            spec_val = req_op[1] ? '0 : INT_MIN;
`ifdef MULDIV_FAST_MUL_EN
        end else if (fast_mul) begin
            spec_val = (req_op[1:0] == 2'b01) ? fast_full[XLEN-1:0]
                                              : fast_full[2*XLEN-1:XLEN];
`endif
        end
    end

    // Negation is applied to the full product so the high half borrows correctly.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        div_res  = sel_hi_q ? core_hi : core_lo;
        div_fix  = neg_q ? (~div_res + 1'b1) : div_res;
        if (is_div_q)
            fix_res = div_fix;
        else
            fix_res = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (core_init),
        .step   (core_step),
        .is_div (is_div_q),
        .init_a (abs_a),
        .init_b (abs_b),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        core_init    = 1'b0;
        core_step    = 1'b0;
        load_special = 1'b0;
        load_fix     = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (spec_hit) begin
                            load_special = 1'b1;
                            state_next   = ST_DONE;
                        end else begin
                            core_init  = 1'b1;
                            state_next = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    core_step = 1'b1;
                    if (counter == CNT_LAST)
                        state_next = ST_FIX;
                end
                ST_FIX: begin
                    load_fix   = 1'b1;
                    state_next = ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            counter <= '0;
        else if (state == ST_CALC && state_next == ST_CALC)
            counter <= counter + CNT_W'(1);
        else
            counter <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_rd   <= '0;
            is_div_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            if (core_init) begin
                is_div_q <= op_div;
                sel_hi_q <= op_div ? req_op[1] : (req_op[1:0] != 2'b01);
                // remainder follows the dividend; product and quotient follow sa^sb
                neg_q    <= (op_div & req_op[1]) ? sa : (sa ^ sb);
                resp_rd  <= req_rd;
            end
            if (load_special) begin
                resp_data <= spec_val;
                resp_rd   <= req_rd;
            end
            if (load_fix)
                resp_data <= fix_res;
        end
    end

    assign req_ready  = (state == ST_IDLE) & ~flush;
    assign resp_valid = (state == ST_DONE) & ~flush;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a 64-bit arithmetic model.
module tb_muldiv_sequencer;
    import alu_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_op = '0;
    logic [XLEN-1:0]  req_a = '0;
    logic [XLEN-1:0]  req_b = '0;
    logic [TAG_W-1:0] req_rd = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_rd;
    logic             busy;

    muldiv_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t q[$];
    int   bp_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ub, r;
        longint unsigned ua, ubu, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ubu = {32'd0, b};
        ub = {32'd0, b};
        r = 0;
        case (op)
            ALU_MUL:    r = sa * sb;
            ALU_MULH:   begin r = sa * sb; r = r >>> 32; end
            ALU_MULHSU: begin r = sa * ub; r = r >>> 32; end
            ALU_MULHU:  begin pu = ua * ubu; r = longint'(pu >> 32); end
            ALU_DIV:    r = (b == 0) ? -1 : sa / sb;
            ALU_DIVU:   r = (b == 0) ? -1 : longint'(ua / ubu);
            ALU_REM:    r = (b == 0) ? sa : sa % sb;
            ALU_REMU:   r = (b == 0) ? sa : longint'(ua % ubu);
            default:    r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[4:3] != 2'b01) return 1;
        if (op[2] && b == 0) return 1;
        if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Response checker: every cycle resp_valid is up, compare against the queue head.
    initial begin : mon
        int hold;
        bit first;
        bit prev_hs;
        hold = 0;
        first = 1'b1;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_ready = 1'b0;
                first = 1'b1;
                prev_hs = 1'b0;
                continue;
            end
            if (prev_hs) begin
                check("bubble_req_ready", 32'(req_ready), 32'd1);
                check("bubble_resp_valid", 32'(resp_valid), 32'd0);
                prev_hs = 1'b0;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got resp_valid=1 data %h expected no response (cycle %0d)", resp_data, cyc);
                    resp_ready = 1'b1;
                end else begin
                    if (first) begin
                        check("latency", 32'(cyc - q[0].t_acc), 32'(q[0].lat));
                        hold = bp_req;
                        first = 1'b0;
                    end
                    check("resp_data", resp_data, q[0].data);
                    check("resp_rd", 32'(resp_rd), 32'(q[0].rd));
                    check("req_ready_in_done", 32'(req_ready), 32'd0);
                    if (hold > 0) begin
                        resp_ready = 1'b0;
                        hold--;
                    end else begin
                        resp_ready = 1'b1;
                        void'(q.pop_front());
                        first = 1'b1;
                        prev_hs = 1'b1;
                    end
                end
            end else begin
                resp_ready = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int bp, input bit push);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_rd = rd;
        bp_req = bp;
        #1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
        end else if (push) begin
            q.push_back('{data: model(op, a, b), rd: rd, lat: model_lat(op, a, b), t_acc: cyc});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got %0d pending expected 0 after 200 cycles", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int bp);
        issue(op, a, b, rd, bp, 1'b1);
        wait_drain();
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : drv
        logic [4:0] op;
        int         r;

        // model pins
        check("pin_div",    model(ALU_DIV,  32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("pin_rem",    model(ALU_REM,  32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("pin_divu",   model(ALU_DIVU, 32'd100, 32'd7), 32'd14);
        check("pin_remu",   model(ALU_REMU, 32'd100, 32'd7), 32'd2);
        check("pin_div0",   model(ALU_DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
        check("pin_rem0",   model(ALU_REM,  32'd5, 32'd0), 32'd5);
        check("pin_divovf", model(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_removf", model(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
        check("pin_mulh",   model(ALU_MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu",  model(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mulhsu", model(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("pin_mul",    model(ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0001);
        check("pin_lat_div",  32'(model_lat(ALU_DIV, 32'd7, 32'd2)), 32'd34);
        check("pin_lat_div0", 32'(model_lat(ALU_DIVU, 32'd5, 32'd0)), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run(ALU_DIV,    32'hFFFF_FFF9, 32'd2, 5'd1, 0);
        run(ALU_REM,    32'hFFFF_FFF9, 32'd2, 5'd2, 0);
        run(ALU_DIVU,   32'd100, 32'd7, 5'd3, 0);
        run(ALU_REMU,   32'd100, 32'd7, 5'd4, 0);
        run(ALU_DIVU,   32'd5, 32'd0, 5'd5, 0);
        run(ALU_REM,    32'd5, 32'd0, 5'd6, 0);
        run(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
        run(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        run(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd9, 0);
        run(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0);
        run(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 0);
        run(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0);
        run(5'b10011,   32'd3, 32'd4, 5'd13, 0);

        // backpressure in DONE
        run(ALU_DIVU, 32'd1234567, 32'd89, 5'd14, 5);
        run(ALU_MUL,  32'd3, 32'hFFFF_FFFB, 5'd15, 5);

        // flush at CALC iteration 10
        issue(ALU_DIVU, 32'd1000, 32'd7, 5'd16, 0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_req_ready", 32'(req_ready), 32'd0);
        check("flush_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy_after", 32'(busy), 32'd0);
        check("flush_resp_valid", 32'(resp_valid), 32'd0);
        repeat (40) @(negedge clk);
        run(ALU_DIVU, 32'd9, 32'd3, 5'd21, 0);

        // reset mid-CALC
        issue(ALU_DIV, 32'd77777, 32'd13, 5'd17, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_resp_data", resp_data, 32'd0);
        check("midrst_resp_rd", 32'(resp_rd), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run(ALU_REMU, 32'd100, 32'd7, 5'd9, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)
                op = 5'b01000 | 5'(r);
            else if (r == 8)
                op = 5'($urandom_range(0, 7));
            else
                op = 5'b10000 | 5'($urandom_range(0, 15));
            run(op, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
